// File: rtl/axis_ram_writer_pkg.sv
// Shared definitions for the RAM write-command stream generator: FSM states,
// command-word layout, length limits and the Galois LFSR step.
package axis_ram_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_FINISH
  } state_t;

  localparam logic [7:0]  LFSR_TAPS_DEFAULT = 8'hB8;
  localparam int unsigned MAX_LEN_DEFAULT   = 256;
  localparam int          LEN_W             = 9;
  localparam int          CMD_W             = 32;

  localparam int ADDR_LSB = 16;
  localparam int DATA_LSB = 0;

  function automatic logic [7:0] lfsr_step(input logic [7:0] cur, input logic [7:0] taps);
    return (cur >> 1) ^ (cur[0] ? taps : 8'h00);
  endfunction

  // Unused fields of the command word are zero.
  function automatic logic [CMD_W-1:0] cmd_word(input logic [7:0] addr, input logic [7:0] data);
    logic [CMD_W-1:0] w;
    w = '0;
    w[ADDR_LSB +: 8] = addr;
    w[DATA_LSB +: 8] = data;
    return w;
  endfunction

endpackage

// File: rtl/axis_ram_writer_if.sv
// AXI-Stream channel carrying RAM write-command words.
interface axis_ram_writer_if;
  import axis_ram_writer_pkg::*;

  logic [CMD_W-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/axis_ram_writer_lfsr8_galois.sv
// 8-bit Galois LFSR with seed load and advance enable; an all-zero seed is
// replaced by 8'h01 so the register can never lock up.
module lfsr8_galois
  import axis_ram_writer_pkg::*;
#(
  parameter logic [7:0] TAPS = LFSR_TAPS_DEFAULT
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] state
);

  logic [7:0] state_q, state_d;

  // NOTE: every variable assigned in always_comb gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (seed == 8'h00) ? 8'h01 : seed;
    end else if (advance) begin
      state_d = lfsr_step(state_q, TAPS);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= 8'h00;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/axis_ram_writer.sv
// Burst generator of {addr, data} write commands for the byte RAM, with a
// running checksum of the data bytes and a cumulative handshake counter.
module axis_ram_writer
  import axis_ram_writer_pkg::*;
#(
  parameter logic [7:0]  LFSR_TAPS = LFSR_TAPS_DEFAULT,
  parameter int unsigned MAX_LEN   = MAX_LEN_DEFAULT
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             start,
  input  logic [7:0]       base_addr,
  input  logic [LEN_W-1:0] length,
  input  logic [7:0]       seed,
  axis_ram_writer_if.master m_axis,
  output logic             busy,
  output logic             done,
  output logic [15:0]      checksum,
  output logic [31:0]      words_sent
);

  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

  state_t           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic [15:0]      checksum_q, checksum_d;
  logic [31:0]      words_sent_q, words_sent_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             tvalid_q, tvalid_d;

  logic             lfsr_load;
  logic             lfsr_advance;
  logic [7:0]       lfsr_state;
  logic [LEN_W-1:0] clamped_len;
  logic             handshake;

  lfsr8_galois #(
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .load    (lfsr_load),
    .seed    (seed),
    .advance (lfsr_advance),
    .state   (lfsr_state)
  );

  assign clamped_len = (length > MAX_LEN_W) ? MAX_LEN_W : length;
  assign handshake   = tvalid_q & m_axis.tready;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    checksum_d   = checksum_q;
    words_sent_d = words_sent_q;
    busy_d       = busy_q;
    tvalid_d     = tvalid_q;
    done_d       = 1'b0;
    lfsr_load    = 1'b0;
    lfsr_advance = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = clamped_len;
          checksum_d  = '0;
          busy_d      = 1'b1;
          lfsr_load   = 1'b1;
          if (clamped_len == '0) begin
            state_d = ST_FINISH;
          end else begin
            state_d  = ST_SEND;
            tvalid_d = 1'b1;
          end
        end
      end

      ST_SEND: begin
        if (handshake) begin
          addr_d       = addr_q + 8'd1;
          lfsr_advance = 1'b1;
          checksum_d   = checksum_q + {8'h00, lfsr_state};
          words_sent_d = words_sent_q + 32'd1;
          remaining_d  = remaining_q - 1'b1;
          if (remaining_q == LEN_W'(1)) begin
            tvalid_d = 1'b0;
            done_d   = 1'b1;
            state_d  = ST_FINISH;
          end
        end
      end

      // FINISH is left only once done has been visible for a cycle; a
      // zero-length burst arrives here without done set and raises it first.
      ST_FINISH: begin
        if (done_q) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          done_d = 1'b1;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        tvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      addr_q       <= 8'h00;
      remaining_q  <= '0;
      checksum_q   <= '0;
      words_sent_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      remaining_q  <= remaining_d;
      checksum_q   <= checksum_d;
      words_sent_q <= words_sent_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      tvalid_q     <= tvalid_d;
    end
  end

  // tdata is pure wiring of the address and LFSR flops, so it holds while stalled.
  assign m_axis.tdata  = cmd_word(addr_q, lfsr_state);
  assign m_axis.tvalid = tvalid_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign checksum      = checksum_q;
  assign words_sent    = words_sent_q;

endmodule
